// File: rtl/lfsr_pixel_buffer_if.sv
// Handshake bundle between the LFSR generator, the capture buffer and the pixel consumer.
// The slave is the buffer. The master drives the capture controls and the consumer ready.
interface lfsr_pixel_buffer_if #(
    parameter int MAX_PIXEL_BITS = 8
);
    logic                      start_i;
    logic [MAX_PIXEL_BITS-1:0] lfsr_data_i;
    logic                      lfsr_done_i;
    logic [MAX_PIXEL_BITS-1:0] pixel_o;
    logic                      pixel_last_o;
    logic                      pixel_valid_o;
    logic                      pixel_ready_i;
    logic                      overflow_o;
    logic                      busy_o;
    logic                      run_done_o;

    modport master (
        output start_i, lfsr_data_i, lfsr_done_i, pixel_ready_i,
        input  pixel_o, pixel_last_o, pixel_valid_o, overflow_o, busy_o, run_done_o
    );

    modport slave (
        input  start_i, lfsr_data_i, lfsr_done_i, pixel_ready_i,
        output pixel_o, pixel_last_o, pixel_valid_o, overflow_o, busy_o, run_done_o
    );
endinterface

// File: rtl/lfsr_pixel_buffer.sv
// Samples the free-running LFSR word once per clock during a run and buffers the samples as a tagged pixel stream.
// A push becomes visible one cycle later. When the consumer stalls, the head is held and samples are dropped on full; the final word waits for room and is never dropped.
module lfsr_pixel_buffer #(
    parameter int MAX_PIXEL_BITS = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clk_i,
    input  logic                nreset_i,
    lfsr_pixel_buffer_if.slave  bus
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, LAST_PEND, DRAIN} state_t;

    typedef struct packed {
        logic                      last;
        logic [MAX_PIXEL_BITS-1:0] dat;
    } entry_t;

    state_t           state, state_nxt;
    entry_t           mem [FIFO_DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty, pop, room;
    logic             push, push_last, drop, flush, busy, last_xfer;
    logic             overflow, run_done;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                       (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign head      = mem[rd_ptr[IDX_W-1:0]];
    assign pop       = !empty && bus.pixel_ready_i;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign room      = !full || pop;
    assign last_xfer = (state == DRAIN) && pop && head.last;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.start_i) state_nxt = CAPTURE;
            CAPTURE:   if (bus.lfsr_done_i) state_nxt = room ? DRAIN : LAST_PEND;
            LAST_PEND: if (room) state_nxt = DRAIN;
            DRAIN:     if (last_xfer) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        drop      = 1'b0;
        flush     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:      flush = bus.start_i;
            CAPTURE: begin
                push      = room;
                push_last = bus.lfsr_done_i;
                drop      = !bus.lfsr_done_i && !room;
            end
            LAST_PEND: begin
                push      = room;
                push_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= '{last: push_last, dat: bus.lfsr_data_i};
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            overflow <= 1'b0;
            run_done <= 1'b0;
        end else begin
            run_done <= last_xfer;
            if (flush) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset. Gating with empty keeps the head at zero after reset.
    assign bus.pixel_o       = empty ? '0 : head.dat;
    assign bus.pixel_last_o  = !empty && head.last;
    assign bus.pixel_valid_o = !empty;
    assign bus.overflow_o    = overflow;
    assign bus.busy_o        = busy;
    assign bus.run_done_o    = run_done;
endmodule

// File: doc/lfsr_pixel_buffer.md
# lfsr_pixel_buffer

Downstream consumer of the LFSR pattern generator. It samples the free-running LFSR word once per clock while a run is active and buffers the samples in a small FIFO. It presents them as a pixel stream with valid/ready handshake and an end-of-run `last` tag. This decouples the non-stallable generator from the grayscale/Sobel pixel path, which may apply backpressure.

## Interface
Parameters:
- `MAX_PIXEL_BITS`, default 8: pixel/LFSR word width.
- `FIFO_DEPTH`, default 4: buffer entries; power of two, ≥2.

Ports:
- `clk_i` input 1: single clock, rising edge.
- `nreset_i` input 1: asynchronous, active-low reset.
- `start_i` input 1: one-cycle pulse that begins a capture run; honoured only in IDLE.
- `lfsr_data_i` input MAX_PIXEL_BITS: current LFSR word, which changes every cycle while the generator runs.
- `lfsr_done_i` input 1: generator finished; the word is frozen while this is high.
- `pixel_o` output MAX_PIXEL_BITS: FIFO head data.
- `pixel_last_o` output 1: head entry is the final word of the run.
- `pixel_valid_o` output 1: FIFO non-empty.
- `pixel_ready_i` input 1: consumer accepts the head this cycle.
- `overflow_o` output 1: sticky flag, set when a sample was dropped in the current/last run.
- `busy_o` output 1: high in any state other than IDLE.
- `run_done_o` output 1: one-cycle pulse when the `last` entry is transferred.

## Operation
- Transfer occurs on any cycle with `pixel_valid_o && pixel_ready_i`. The head is popped at that edge.
- FSM states: IDLE, CAPTURE, LAST_PEND, DRAIN.
- **IDLE:**
  - `start_i`=1 → CAPTURE, flush FIFO, clear `overflow_o`.
  - `start_i` outside IDLE is ignored.
- **CAPTURE, `lfsr_done_i`=0:**
  - Push `{last=0, lfsr_data_i}`.
  - If the FIFO is full and no pop occurs this cycle, drop the sample and set `overflow_o`.
  - Full with a simultaneous pop: the push succeeds.
- **CAPTURE, `lfsr_done_i`=1:**
  - Push `{last=1, lfsr_data_i}` and go to DRAIN.
  - If full with no pop, go to LAST_PEND instead. Nothing is dropped and `overflow_o` is not set.
- **LAST_PEND:** push `{last=1, lfsr_data_i}` on the first cycle the FIFO has room (not full, or pop this cycle), then go to DRAIN. The word is stable because the generator is done.
- **DRAIN:** no pushes. When the `last` entry transfers, pulse `run_done_o` and go to IDLE.
- If `lfsr_done_i` is already high on the first CAPTURE cycle, the run yields exactly one entry, tagged `last`.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap modulo 2·FIFO_DEPTH. Full = MSBs differ and LSBs are equal. Empty = pointers equal.
- Occupancy never exceeds FIFO_DEPTH. A pop on empty is impossible because valid gates it.
- Reset mid-run: state → IDLE, FIFO empty, all flags cleared. Any in-flight data is discarded.

## Timing
- Reset values: `pixel_o`=0, `pixel_last_o`=0, `pixel_valid_o`=0, `overflow_o`=0, `busy_o`=0, `run_done_o`=0, state IDLE, pointers 0.
- `start_i` high at edge N → `busy_o` high after N. The first sample is taken at edge N+1.
- Push at edge K → `pixel_valid_o` high after K, i.e. one cycle of latency. Head data is registered from FIFO storage.
- With the consumer always ready and no overflow, throughput is 1 pixel/clock and the output stream equals the sampled LFSR sequence shifted one cycle.
- While `pixel_valid_o && !pixel_ready_i`, `pixel_o` and `pixel_last_o` hold stable.
- `overflow_o` sets at the edge where the drop occurs and holds until the next accepted `start_i`.
- `run_done_o` is high for exactly the cycle after the edge at which `last` transfers. `busy_o` falls at that same edge.

## Test plan
- **Basic run:** `lfsr_data_i` = 0x01..0x05 over cycles, `lfsr_done_i` rises with 0x06, ready=1 → 6 pixels 0x01..0x06, `last` only on 0x06, `run_done_o` pulses once, `overflow_o`=0.
- **Backpressure, no loss:** ready=0 for 3 cycles mid-run with FIFO_DEPTH=4 and 3 samples → output holds stable, then all samples are delivered in order.
- **Overflow:** ready=0 for an entire 10-word run → first 4 words retained, `overflow_o`=1. When done rises, the FSM sits in LAST_PEND. On ready=1 the output is the 4 words followed by the final word with `last`.
- **Immediate done:** `lfsr_done_i`=1 at start with data 0xA5 → single pixel 0xA5, last=1, then `run_done_o`.
- **Full with simultaneous push/pop:** FIFO full, ready=1 for one cycle during CAPTURE → no drop, `overflow_o` stays 0, occupancy unchanged.
- **Reset mid-run:** assert `nreset_i`=0 with 3 entries buffered → all outputs 0 immediately. `start_i` during DRAIN of the next run is ignored.
